// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC key/display block.
//   SEED_DEFAULT : reset key, also used when a zero key is loaded
//   TAPS_DEFAULT : Galois LFSR feedback mask
//   NUM_DIGITS   : digits on the multiplexed 7-seg display
//   hex_to_seg() : hex nibble -> {g,f,e,d,c,b,a}, active-high
package rtc_pkg;

   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
   localparam logic [15:0] TAPS_DEFAULT = 16'hB400;
   localparam int          NUM_DIGITS   = 4;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/rtc_tick_sync.sv
// Turns a slow divider output into one-cycle ticks in the sys_clk domain.
// Every level change (rising or falling) of level_in is one tick.
//   sys_clk  : system clock
//   rst_n    : asynchronous active-low reset
//   level_in : slow level from the divider (asynchronous to sys_clk)
//   tick_out : high for one sys_clk cycle per level change
module rtc_tick_sync
   import rtc_pkg::*;
(
   input  logic sys_clk,
   input  logic rst_n,
   input  logic level_in,
   output logic tick_out
);

   logic       s1;
   logic       s2;
   logic       prv;
   logic [1:0] warm_cnt;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         prv      <= 1'b0;
         warm_cnt <= 2'd0;
      end else begin
         s1  <= level_in;
         s2  <= s1;
         prv <= s2;
         if (warm_cnt != 2'd3) begin
            warm_cnt <= warm_cnt + 2'd1;
         end
      end
   end

   // The flops come out of reset at 0, so a level that is already high at
   // release would look like a change. Suppressing ticks for the first three
   // edges after release covers exactly that pipeline fill.
   assign tick_out = (s2 ^ prv) & (warm_cnt == 2'd3);

endmodule

// File: rtl/rtc_key_display.sv
// Key generator and display driver fed by the RTC divider outputs.
// clk_5s toggles step a 16-bit Galois LFSR key; clk_500Hz toggles scan a
// 4-digit multiplexed 7-seg display showing the key in hex.
//   sys_clk   : system clock, the only clock
//   rst_n     : asynchronous active-low reset
//   clk_500Hz : scan tick level (each toggle = advance one digit)
//   clk_5s    : key tick level (each toggle = one LFSR step)
//   load_en   : load load_key this cycle (beats a same-cycle key tick)
//   load_key  : key to load; zero is replaced by SEED
//   key       : current key, never zero
//   key_valid : one-cycle pulse after every key update
//   key_count : key ticks since reset or last load, wraps at 256
//   digit_an  : active-low digit enables, one-hot-zero
//   seg       : active-high segments {g,f,e,d,c,b,a}
module rtc_key_display
   import rtc_pkg::*;
#(
   parameter logic [15:0] SEED = SEED_DEFAULT,
   parameter logic [15:0] TAPS = TAPS_DEFAULT
)
(
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        clk_500Hz,
   input  logic        clk_5s,
   input  logic        load_en,
   input  logic [15:0] load_key,
   output logic [15:0] key,
   output logic        key_valid,
   output logic [7:0]  key_count,
   output logic [3:0]  digit_an,
   output logic [6:0]  seg
);

   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic             scan_tick;
   logic             key_tick;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [15:0]      lfsr_nxt;
   logic [3:0]       nib_nxt;

   rtc_tick_sync u_scan_sync (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .level_in (clk_500Hz),
      .tick_out (scan_tick)
   );

   rtc_tick_sync u_key_sync (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .level_in (clk_5s),
      .tick_out (key_tick)
   );

   always_comb begin
      idx_nxt  = scan_tick ? idx + 1'b1 : idx;
      lfsr_nxt = (key >> 1) ^ (key[0] ? TAPS : 16'h0000);
      // Segments are built from the key as it stands before this edge's
      // update, so seg trails a key change by one cycle while digit_an and
      // seg always refer to the same digit.
      nib_nxt  = key[{idx_nxt, 2'b00} +: 4];
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         key       <= SEED;
         key_valid <= 1'b0;
         key_count <= 8'd0;
         idx       <= '0;
         digit_an  <= 4'b1110;
         seg       <= hex_to_seg(SEED[3:0]);
      end else begin
         if (load_en) begin
            // A key tick in the same cycle is intentionally discarded.
            key       <= (load_key == 16'h0000) ? SEED : load_key;
            key_count <= 8'd0;
            key_valid <= 1'b1;
         end else if (key_tick) begin
            key       <= lfsr_nxt;
            key_count <= key_count + 8'd1;
            key_valid <= 1'b1;
         end else begin
            key_valid <= 1'b0;
         end
         idx      <= idx_nxt;
         digit_an <= ~(4'b0001 << idx_nxt);
         seg      <= hex_to_seg(nib_nxt);
      end
   end

endmodule

// File: tb/tb_rtc_key_display.sv
// Bench for rtc_key_display: directed steps plus random toggles/loads, all
// outputs compared every cycle against an event-timed reference model.
module tb_rtc_key_display;

   logic        sys_clk;
   logic        rst_n;
   logic        clk_500Hz;
   logic        clk_5s;
   logic        load_en;
   logic [15:0] load_key;
   logic [15:0] key;
   logic        key_valid;
   logic [7:0]  key_count;
   logic [3:0]  digit_an;
   logic [6:0]  seg;

   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   rtc_key_display dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .clk_500Hz (clk_500Hz),
      .clk_5s    (clk_5s),
      .load_en   (load_en),
      .load_key  (load_key),
      .key       (key),
      .key_valid (key_valid),
      .key_count (key_count),
      .digit_an  (digit_an),
      .seg       (seg)
   );

   // ---------------- clock ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- reference model ----------------
   int          n_tests;
   int          n_fail;
   int          cyc;
   int          rel_edge;
   logic [15:0] m_key;
   logic [7:0]  m_count;
   logic        m_valid;
   int          m_idx;
   logic [6:0]  m_seg;
   logic        m_prev_5s;
   logic        m_prev_500;
   int          key_due[$];
   int          scan_due[$];

   function automatic logic [15:0] lfsr_step(input logic [15:0] k);
      return (k >> 1) ^ (k[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset();
      m_key      = 16'hACE1;
      m_count    = 8'd0;
      m_valid    = 1'b0;
      m_idx      = 0;
      m_seg      = FONT[1];
      m_prev_5s  = 1'b0;
      m_prev_500 = 1'b0;
      key_due.delete();
      scan_due.delete();
   endtask

   // One sys_clk edge: a level change seen at edge e takes effect at e+2,
   // and nothing takes effect within the first three edges after release.
   task automatic model_edge();
      int          e;
      bit          k_tick;
      bit          s_tick;
      logic [15:0] old_key;
      logic [3:0]  nib;
      if (!rst_n) return;
      e      = cyc;
      k_tick = 0;
      s_tick = 0;
      if (key_due.size() > 0 && key_due[0] == e) begin
         void'(key_due.pop_front());
         k_tick = (e > rel_edge + 3);
      end
      if (scan_due.size() > 0 && scan_due[0] == e) begin
         void'(scan_due.pop_front());
         s_tick = (e > rel_edge + 3);
      end
      if (clk_5s !== m_prev_5s) key_due.push_back(e + 2);
      if (clk_500Hz !== m_prev_500) scan_due.push_back(e + 2);
      m_prev_5s  = clk_5s;
      m_prev_500 = clk_500Hz;
      old_key = m_key;
      if (load_en) begin
         m_key   = (load_key == 16'h0000) ? 16'hACE1 : load_key;
         m_count = 8'd0;
         m_valid = 1'b1;
      end else if (k_tick) begin
         m_key   = lfsr_step(m_key);
         m_count = m_count + 8'd1;
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (s_tick) m_idx = (m_idx + 1) % 4;
      nib   = 4'((old_key >> (4 * m_idx)) & 16'h000F);
      m_seg = FONT[nib];
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
         $error("%s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << m_idx);
      chk("key",       key,                  m_key);
      chk("key_valid", {15'd0, key_valid},   {15'd0, m_valid});
      chk("key_count", {8'd0, key_count},    {8'd0, m_count});
      chk("digit_an",  {12'd0, digit_an},    {12'd0, exp_an});
      chk("seg",       {9'd0, seg},          {9'd0, m_seg});
      chk("key_nonzero", {15'd0, (key == 16'h0000)}, 16'h0000);
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge; outputs are checked there too.
   task automatic step();
      @(posedge sys_clk);
      cyc++;
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_load(input logic [15:0] k);
      load_key = k;
      load_en  = 1'b1;
      step();
      load_en  = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ref_key;
      logic [3:0]  an_tab  [4];
      logic [6:0]  seg_tab [4];
      an_tab  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      seg_tab = '{7'h4F, 7'h5B, 7'h06, 7'h66};

      n_tests   = 0;
      n_fail    = 0;
      cyc       = 0;
      rel_edge  = 0;
      rst_n     = 1'b0;
      clk_500Hz = 1'b0;
      clk_5s    = 1'b0;
      load_en   = 1'b0;
      load_key  = 16'h0000;
      model_reset();

      // 1: reset values
      repeat (5) step();
      chk("t1_key", key, 16'hACE1);
      chk("t1_an",  {12'd0, digit_an}, 16'h000E);
      chk("t1_seg", {9'd0, seg}, 16'h0006);
      chk("t1_cnt", {8'd0, key_count}, 16'h0000);
      chk("t1_vld", {15'd0, key_valid}, 16'h0000);

      // 2: high level right after release is masked, then one real toggle
      rst_n    = 1'b1;
      rel_edge = cyc;
      clk_5s   = 1'b1;
      repeat (6) step();
      chk("t2_nokey", key, 16'hACE1);
      clk_5s = 1'b0;
      step();
      step();
      chk("t2_n1_key", key, 16'hACE1);
      step();
      chk("t2_key", key, 16'hE270);
      chk("t2_vld", {15'd0, key_valid}, 16'h0001);
      chk("t2_cnt", {8'd0, key_count}, 16'h0001);
      step();
      chk("t2_vld_off", {15'd0, key_valid}, 16'h0000);

      // 3: load collides with a key tick; then zero load
      clk_5s = 1'b1;
      step();
      step();
      do_load(16'h1234);
      chk("t3_key", key, 16'h1234);
      chk("t3_cnt", {8'd0, key_count}, 16'h0000);
      repeat (4) step();
      chk("t3_lost", key, 16'h1234);
      do_load(16'h0000);
      chk("t3_zero", key, 16'hACE1);
      step();
      do_load(16'h1234);
      repeat (2) step();

      // 4: scan through all four digits of 1234
      for (int i = 0; i < 4; i++) begin
         clk_500Hz = ~clk_500Hz;
         repeat (100) step();
         chk("t4_an",  {12'd0, digit_an}, {12'd0, an_tab[i]});
         chk("t4_seg", {9'd0, seg}, {9'd0, seg_tab[i]});
      end

      // 5: 256 key ticks, count wraps, key against an independent LFSR walk
      ref_key = 16'h1234;
      for (int i = 0; i < 256; i++) begin
         clk_5s  = ~clk_5s;
         ref_key = lfsr_step(ref_key);
         repeat ($urandom_range(3, 6)) step();
      end
      repeat (4) step();
      chk("t5_cnt", {8'd0, key_count}, 16'h0000);
      chk("t5_key", key, ref_key);

      // 6: reset mid-scan with clk_5s held high through release
      for (int i = 0; i < 7; i++) begin
         clk_5s = ~clk_5s;
         repeat ($urandom_range(2, 5)) step();
      end
      for (int i = 0; i < 2; i++) begin
         clk_500Hz = ~clk_500Hz;
         repeat ($urandom_range(3, 6)) step();
      end
      repeat (3) step();
      chk("t6_cnt7", {8'd0, key_count}, 16'h0007);
      chk("t6_idx2", {12'd0, digit_an}, 16'h000B);
      rst_n  = 1'b0;
      clk_5s = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("t6_rst_key", key, 16'hACE1);
      chk("t6_rst_an",  {12'd0, digit_an}, 16'h000E);
      chk("t6_rst_cnt", {8'd0, key_count}, 16'h0000);
      repeat (3) step();
      rst_n    = 1'b1;
      rel_edge = cyc;
      repeat (10) step();
      chk("t6_hold_key", key, 16'hACE1);
      chk("t6_hold_cnt", {8'd0, key_count}, 16'h0000);
      chk("t6_hold_vld", {15'd0, key_valid}, 16'h0000);

      // 7: random mix of key ticks, scan ticks and loads
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) clk_5s = ~clk_5s;
         if ($urandom_range(0, 4) == 0) clk_500Hz = ~clk_500Hz;
         if ($urandom_range(0, 19) == 0) begin
            load_en  = 1'b1;
            load_key = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         end else begin
            load_en = 1'b0;
         end
         step();
      end
      load_en = 1'b0;
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
